// File: rtl/frame_slot_arbiter.sv
// frame_slot_arbiter: frame-granular round-robin sharing of one FIFO write port between two sources
module frame_slot_arbiter #(
  parameter int PREAMBLE_LEN = 8,
  parameter int PAYLOAD_LEN = 32,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_0,
  input  logic req_1,
  input  logic data_0,
  input  logic data_1,
  input  logic we_0,
  input  logic we_1,
  output logic gnt_0,
  output logic gnt_1,
  output logic full_0,
  output logic full_1,
  output logic fifo_out_data,
  output logic fifo_out_we,
  input  logic fifo_out_full,
  output logic frame_done,
  output logic abort,
  output logic protocol_err
);
  localparam int FRAME_LEN = PREAMBLE_LEN + PAYLOAD_LEN;
  localparam int BW = $clog2(FRAME_LEN + 1);
  localparam int IW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  state_t state, state_nx;
  logic src, src_nx, last_src, last_src_nx;
  logic [BW-1:0] bit_cnt, bit_cnt_nx;
  logic [IW-1:0] idle_cnt, idle_cnt_nx;
  logic done_nx, abort_nx, perr_nx, we_g, last_bit, timed_out;
  assign gnt_0 = state == XFER && !src;
  assign gnt_1 = state == XFER && src;
  assign full_0 = gnt_0 ? fifo_out_full : 1'b1;
  assign full_1 = gnt_1 ? fifo_out_full : 1'b1;
  assign we_g = src ? we_1 : we_0;
  assign fifo_out_we = state == XFER && we_g;
  assign fifo_out_data = state == XFER && (src ? data_1 : data_0);
  assign last_bit = we_g && bit_cnt == BW'(FRAME_LEN - 1);
  assign timed_out = TIMEOUT != 0 && !we_g && idle_cnt == IW'(TIMEOUT - 1);
  always_comb begin
    state_nx = state;
    src_nx = src;
    last_src_nx = last_src;
    bit_cnt_nx = bit_cnt;
    idle_cnt_nx = idle_cnt;
    done_nx = 1'b0;
    abort_nx = 1'b0;
    perr_nx = (we_0 && !gnt_0) || (we_1 && !gnt_1);
    case (state)
      IDLE: if (req_0 || req_1) begin
        state_nx = XFER;
        src_nx = req_0 && req_1 ? !last_src : req_1;
        bit_cnt_nx = '0;
        idle_cnt_nx = '0;
      end
      XFER: begin
        bit_cnt_nx = we_g ? bit_cnt + 1'b1 : bit_cnt;
        idle_cnt_nx = we_g ? '0 : idle_cnt + 1'b1;
        if (last_bit || timed_out) begin
          state_nx = GAP;
          last_src_nx = src;
          done_nx = last_bit;
          abort_nx = timed_out;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      src <= 1'b0;
      last_src <= 1'b1;
      bit_cnt <= '0;
      idle_cnt <= '0;
      frame_done <= 1'b0;
      abort <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nx;
      src <= src_nx;
      last_src <= last_src_nx;
      bit_cnt <= bit_cnt_nx;
      idle_cnt <= idle_cnt_nx;
      frame_done <= done_nx;
      abort <= abort_nx;
      protocol_err <= perr_nx;
    end
  end
endmodule

// File: tb/tb_frame_slot_arbiter.sv
// tb_frame_slot_arbiter: directed stimulus checked every cycle against a slot-level model plus literal totals
`timescale 1ns/1ps
module tb_frame_slot_arbiter;
  localparam int FRAME_LEN = 40;
  localparam int TIMEOUT = 64;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_0 = 1'b0, req_1 = 1'b0, data_0 = 1'b0, data_1 = 1'b0, we_0 = 1'b0, we_1 = 1'b0, fifo_out_full = 1'b0;
  logic gnt_0, gnt_1, full_0, full_1, fifo_out_data, fifo_out_we, frame_done, abort, protocol_err;
  int n_tests = 0, n_fail = 0, cyc = 0;
  int m_owner = -1, m_written = 0, m_quiet = 0, m_last = 1, m_frames = 0;
  bit m_gap = 0, m_done = 0, m_abort = 0, m_perr = 0;
  bit [1:0] wr_en = '0;
  int limit [2] = '{40, 40};
  int stall_at = -1, stall_left = 0, rogue_at = -1, rogue_left = 0;
  int cnt_g0, cnt_g1, cnt_we, cnt_done, cnt_abort, cnt_perr, cnt_stall, last_we_cyc, abort_gap;
  int order[$];
  logic pg0 = 1'b0, pg1 = 1'b0, e_we, e_d;

  frame_slot_arbiter #(.PREAMBLE_LEN(8), .PAYLOAD_LEN(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_0(req_0), .req_1(req_1), .data_0(data_0), .data_1(data_1),
    .we_0(we_0), .we_1(we_1), .gnt_0(gnt_0), .gnt_1(gnt_1), .full_0(full_0), .full_1(full_1),
    .fifo_out_data(fifo_out_data), .fifo_out_we(fifo_out_we), .fifo_out_full(fifo_out_full),
    .frame_done(frame_done), .abort(abort), .protocol_err(protocol_err));

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_written = 0; m_quiet = 0; m_last = 1; m_gap = 0;
    m_done = 0; m_abort = 0; m_perr = 0;
  endtask

  task automatic model_update();
    logic wg;
    m_perr = (we_0 && m_owner != 0) || (we_1 && m_owner != 1);
    m_done = 0;
    m_abort = 0;
    if (m_owner >= 0) begin
      wg = m_owner == 1 ? we_1 : we_0;
      if (wg) begin m_written++; m_quiet = 0; end else m_quiet++;
      if (m_written == FRAME_LEN || (TIMEOUT != 0 && m_quiet == TIMEOUT)) begin
        m_done = m_written == FRAME_LEN;
        m_abort = !m_done;
        if (m_done) m_frames++;
        m_last = m_owner;
        m_owner = -1;
        m_gap = 1;
      end
    end else if (m_gap) m_gap = 0;
    else if (req_0 || req_1) begin
      m_owner = req_0 && req_1 ? 1 - m_last : (req_1 ? 1 : 0);
      m_written = 0;
      m_quiet = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset(); else model_update();
  end

  initial forever begin
    @(negedge clk);
    #2;
    cyc++;
    e_we = m_owner == 0 ? we_0 : m_owner == 1 ? we_1 : 1'b0;
    e_d = m_owner == 0 ? data_0 : m_owner == 1 ? data_1 : 1'b0;
    check("gnt_0", gnt_0, m_owner == 0);
    check("gnt_1", gnt_1, m_owner == 1);
    check("full_0", full_0, m_owner == 0 ? fifo_out_full : 1'b1);
    check("full_1", full_1, m_owner == 1 ? fifo_out_full : 1'b1);
    check("fifo_out_we", fifo_out_we, e_we);
    check("fifo_out_data", fifo_out_data, e_d);
    check("frame_done", frame_done, m_done);
    check("abort", abort, m_abort);
    check("protocol_err", protocol_err, m_perr);
    if (gnt_0) cnt_g0++;
    if (gnt_1) cnt_g1++;
    if (gnt_0 && !pg0) order.push_back(0);
    if (gnt_1 && !pg1) order.push_back(1);
    pg0 = gnt_0;
    pg1 = gnt_1;
    if (fifo_out_we) begin cnt_we++; last_we_cyc = cyc; end
    if (frame_done) cnt_done++;
    if (abort) begin cnt_abort++; abort_gap = cyc - last_we_cyc; end
    if (protocol_err) cnt_perr++;
    if (gnt_0 && full_0) cnt_stall++;
  end

  function automatic logic src_we(int n);
    return wr_en[n] && m_owner == n && m_written < limit[n] && !fifo_out_full;
  endfunction

  task automatic step();
    @(negedge clk);
    data_0 = 1'($urandom_range(0, 1));
    data_1 = 1'($urandom_range(0, 1));
    fifo_out_full = stall_left > 0 && m_owner >= 0 && m_written == stall_at;
    if (fifo_out_full) stall_left--;
    we_0 = src_we(0);
    we_1 = src_we(1);
    if (rogue_left > 0 && m_owner == 0 && m_written == rogue_at) begin
      we_1 = 1'b1;
      rogue_left--;
    end
  endtask

  function automatic int probe(int kind);
    return kind == 0 ? m_owner : kind == 1 ? m_written : m_frames;
  endfunction

  task automatic wait_until(string name, int kind, int target);
    int g = 0;
    do begin step(); g++; end while (probe(kind) != target && g < 400);
    check(name, probe(kind), target);
  endtask

  task automatic clear_counts();
    cnt_g0 = 0; cnt_g1 = 0; cnt_we = 0; cnt_done = 0; cnt_abort = 0; cnt_perr = 0;
    cnt_stall = 0; last_we_cyc = 0; abort_gap = -1; m_frames = 0;
    order.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_0 = 1'b0; req_1 = 1'b0; wr_en = '0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic tail();
    repeat (6) step();
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) step();
    #3;
    check("rst_gnt_0", gnt_0, 0);
    check("rst_full_1", full_1, 1);
    check("rst_fifo_we", fifo_out_we, 0);
    check("rst_fifo_data", fifo_out_data, 0);
    do_reset();
    clear_counts();
    req_0 = 1'b1; wr_en = 2'b01;
    wait_until("t1_grant", 0, 0);
    req_0 = 1'b0;
    wait_until("t1_frames", 2, 1);
    tail();
    check("t1_gnt0_cycles", cnt_g0, 40);
    check("t1_gnt1_cycles", cnt_g1, 0);
    check("t1_writes", cnt_we, 40);
    check("t1_done", cnt_done, 1);
    check("t1_abort", cnt_abort, 0);

    do_reset();
    clear_counts();
    req_0 = 1'b1; req_1 = 1'b1; wr_en = 2'b11;
    wait_until("t2_frames", 2, 4);
    req_0 = 1'b0; req_1 = 1'b0;
    tail();
    check("t2_slots", order.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_order", order[i], i % 2);
    check("t2_writes", cnt_we, 160);
    check("t2_done", cnt_done, 4);
    check("t2_gnt0_cycles", cnt_g0, 80);
    check("t2_gnt1_cycles", cnt_g1, 80);

    do_reset();
    clear_counts();
    req_0 = 1'b1; wr_en = 2'b01; stall_at = 15; stall_left = 10;
    wait_until("t3_grant", 0, 0);
    req_0 = 1'b0;
    wait_until("t3_frames", 2, 1);
    tail();
    check("t3_writes", cnt_we, 40);
    check("t3_done", cnt_done, 1);
    check("t3_abort", cnt_abort, 0);
    check("t3_gnt0_cycles", cnt_g0, 50);
    check("t3_full_cycles", cnt_stall, 10);
    stall_at = -1;

    do_reset();
    clear_counts();
    req_1 = 1'b1; wr_en = 2'b11; limit[1] = 20;
    wait_until("t4_grant1", 0, 1);
    req_0 = 1'b1;
    wait_until("t4_grant0", 0, 0);
    req_0 = 1'b0; req_1 = 1'b0;
    wait_until("t4_frames", 2, 1);
    tail();
    check("t4_abort", cnt_abort, 1);
    check("t4_abort_gap", abort_gap, 65);
    check("t4_gnt1_cycles", cnt_g1, 84);
    check("t4_slots", order.size(), 2);
    check("t4_first", order[0], 1);
    check("t4_second", order[1], 0);
    check("t4_writes", cnt_we, 60);
    check("t4_done", cnt_done, 1);
    limit[1] = 40;

    do_reset();
    clear_counts();
    req_0 = 1'b1; wr_en = 2'b01; rogue_at = 10; rogue_left = 1;
    wait_until("t5_grant", 0, 0);
    req_0 = 1'b0;
    wait_until("t5_frames", 2, 1);
    tail();
    check("t5_perr", cnt_perr, 1);
    check("t5_writes", cnt_we, 40);
    check("t5_done", cnt_done, 1);

    clear_counts();
    req_0 = 1'b1; wr_en = 2'b01;
    wait_until("t6_grant", 0, 0);
    req_0 = 1'b0;
    wait_until("t6_bit17", 1, 17);
    #1 rst_n = 1'b0;
    #2;
    check("t6_async_gnt_0", gnt_0, 0);
    check("t6_async_full_0", full_0, 1);
    check("t6_async_fifo_we", fifo_out_we, 0);
    check("t6_async_fifo_data", fifo_out_data, 0);
    check("t6_async_done", frame_done, 0);
    repeat (3) step();
    rst_n = 1'b1;
    clear_counts();
    req_0 = 1'b1; req_1 = 1'b1; wr_en = 2'b11;
    wait_until("t6_regrant", 0, 0);
    req_0 = 1'b0; req_1 = 1'b0;
    wait_until("t6_frames", 2, 1);
    tail();
    check("t6_first", order[0], 0);
    check("t6_slots", order.size(), 1);
    check("t6_done", cnt_done, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_slot_arbiter.md
# frame_slot_arbiter

Round-robin scheduler that shares one output-FIFO write port between two frame sources at frame granularity. Each source requests a slot, receives an exclusive grant for exactly one frame (PREAMBLE_LEN + PAYLOAD_LEN bits), and its bit stream is muxed onto the FIFO write port. The block sits between two frame-forming blocks and the output FIFO that feeds the frame finder, so frames from both sources reach the channel unbroken.

## Interface
- PREAMBLE_LEN, 8: preamble bits per frame.
- PAYLOAD_LEN, 32: payload bits per frame.
- TIMEOUT, 64: maximum cycles without a write inside a granted slot before the slot is aborted; 0 disables the timeout.
- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ_0, REQ_1  in  1  source n has a complete frame ready; level, held until granted.
- DATA_0, DATA_1  in  1  source n bit.
- WE_0, WE_1  in  1  source n write strobe.
- GNT_0, GNT_1  out  1  slot granted to source n; held for the whole slot.
- FULL_0, FULL_1  out  1  backpressure to source n: FIFO_OUT_FULL while granted, 1 otherwise.
- FIFO_OUT_DATA  out  1  muxed bit to output FIFO.
- FIFO_OUT_WE  out  1  muxed write strobe.
- FIFO_OUT_FULL  in  1  output FIFO full.
- FRAME_DONE  out  1  one-cycle pulse: slot completed with FRAME_LEN writes.
- ABORT  out  1  one-cycle pulse: slot ended by timeout.
- PROTOCOL_ERR  out  1  one-cycle pulse: write strobe from a non-granted source.

## Operation
- FRAME_LEN = PREAMBLE_LEN + PAYLOAD_LEN; bit counter width clog2(FRAME_LEN+1), idle counter width clog2(TIMEOUT+1) (min 1).
- States: IDLE, XFER, GAP.
- IDLE: no grant. If REQ_0 or REQ_1 sampled high, grant the requester with priority; priority goes to the source NOT served last (last_src resets to 1, so source 0 wins the first tie). Register GNT_n, clear counters, go XFER.
- XFER: FIFO_OUT_DATA = DATA_g, FIFO_OUT_WE = WE_g (combinational mux of granted source g). Arbiter does not gate WE with FULL; the granted source must obey FULL_g. Each cycle WE_g=1 increments bit counter and clears idle counter; each cycle WE_g=0 increments idle counter.
- Bit counter reaches FRAME_LEN (write on the cycle when it equals FRAME_LEN-1): deassert GNT, pulse FRAME_DONE, last_src = g, go GAP.
- TIMEOUT != 0 and idle counter reaches TIMEOUT: deassert GNT, pulse ABORT, last_src = g, go GAP. Partial frame stays in FIFO; frame finder resynchronises.
- GAP: one cycle, no grant, then IDLE. Guarantees at least one dead cycle between slots.
- Outside XFER, or from the non-granted source: WE ignored (never reaches FIFO_OUT_WE). If a non-granted WE is seen, PROTOCOL_ERR pulses next cycle.
- REQ of the granted source is ignored during XFER; re-sampled only in IDLE.
- FIFO_OUT_DATA = 0 when no grant.

## Timing
- Reset (RESET=0, async): state IDLE, GNT_0=GNT_1=0, FULL_0=FULL_1=1, FIFO_OUT_WE=0, FIFO_OUT_DATA=0, FRAME_DONE=ABORT=PROTOCOL_ERR=0, counters 0, last_src=1. Reset mid-slot drops the grant immediately; the partial frame is not completed.
- Grant latency: REQ high at edge k (in IDLE) -> GNT high after edge k; first write accepted at edge k+1.
- Data path: zero latency, WE_g/DATA_g to FIFO_OUT_WE/FIFO_OUT_DATA combinational while GNT_g=1.
- FRAME_DONE/ABORT: registered, high in the cycle after the final write / timeout edge, coincident with GNT low (GAP state).
- Back-to-back requests: minimum slot period FRAME_LEN + 2 cycles (grant, FRAME_LEN writes, GAP). Since the grant cycle overlaps the first write, continuous operation gives FRAME_LEN writes every FRAME_LEN+2 cycles.
- FULL_g asserted mid-slot: writes stall and the idle counter runs. A FIFO stalled longer than TIMEOUT aborts the slot.

## Test plan
- Single source: REQ_0 held, source 0 writes 40 bits contiguously -> GNT_0 high 40 cycles, FIFO_OUT_WE 40 pulses with data matching DATA_0, one FRAME_DONE, GNT_1 never high.
- Tie and rotation: REQ_0=REQ_1=1 from reset, both stream frames -> grants alternate 0,1,0,1, one GAP cycle between slots, 160 bits in 4 frames, no interleaving.
- Backpressure: FIFO_OUT_FULL high 10 cycles mid-slot, TIMEOUT=64 -> FULL_g follows it, slot completes, FRAME_DONE, no ABORT.
- Timeout: source 1 granted, stops after 20 bits -> ABORT pulse 64 cycles after last write, GNT_1 low, next grant goes to source 0 if requesting.
- Rogue write: WE_1 pulsed while GNT_0 active -> FIFO_OUT_WE unaffected, PROTOCOL_ERR pulses once.
- Reset mid-slot: RESET low at bit 17 -> all outputs at reset values asynchronously; after release, REQ_1 and REQ_0 both high -> source 0 granted first.
